// File: rtl/ws2812_pkg.sv
// Shared types and default timing for the WS2812/SK6812 pixel serializer.
// Default timing constants are clock counts at 200 MHz.
package ws2812_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_LATCH
   } state_t;

   localparam int unsigned T0H_DEF    = 70;
   localparam int unsigned T1H_DEF    = 140;
   localparam int unsigned PERIOD_DEF = 250;
   localparam int unsigned LATCH_DEF  = 56000;

endpackage

// File: rtl/ws2812_bit_gen.sv
// One NRZ bit code: counts 0..period-1, line high while count < th.
// A start on the bit_end cycle chains the next bit with no gap.
module ws2812_bit_gen #(
   parameter int CNT_W = 16
) (
   input  logic             clk_in,
   input  logic             rst_n_in,
   input  logic             start_i,
   input  logic [CNT_W-1:0] th_i,
   input  logic [CNT_W-1:0] period_i,
   output logic             data_o,
   output logic             bit_end_o
);
   import ws2812_pkg::*;

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] th_q;
   logic [CNT_W-1:0] per_q;
   logic             run_q;
   logic             data_q;

   assign bit_end_o = run_q && (cnt_q == per_q - 1'b1);
   assign data_o    = data_q;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         cnt_q  <= '0;
         th_q   <= '0;
         per_q  <= '0;
         run_q  <= 1'b0;
         data_q <= 1'b0;
      end else if (start_i) begin
         cnt_q  <= '0;
         th_q   <= th_i;
         per_q  <= period_i;
         run_q  <= 1'b1;
         data_q <= (th_i != '0);
      end else if (run_q) begin
         if (bit_end_o) begin
            cnt_q  <= '0;
            run_q  <= 1'b0;
            data_q <= 1'b0;
         end else begin
            cnt_q  <= cnt_q + 1'b1;
            data_q <= ((cnt_q + 1'b1) < th_q);
         end
      end
   end

endmodule

// File: rtl/ws2812_pixel_out.sv
// WS2812/SK6812 pixel serializer: one-entry holding register, MSB-first
// shift register, gapless pixel chaining and frame latch generation.
module ws2812_pixel_out
   import ws2812_pkg::*;
#(
   parameter int BITS_PER_PIXEL = 24,
   parameter int CNT_W          = 16,
   parameter int LATCH_W        = 16
) (
   input  logic                      clk_in,
   input  logic                      rst_n_in,
   input  logic [CNT_W-1:0]          t0h_in,
   input  logic [CNT_W-1:0]          t1h_in,
   input  logic [CNT_W-1:0]          period_in,
   input  logic [LATCH_W-1:0]        latch_in,
   input  logic                      pix_valid_in,
   input  logic [BITS_PER_PIXEL-1:0] pix_data_in,
   input  logic                      pix_last_in,
   output logic                      pix_ready_out,
   output logic                      busy_out,
   output logic                      frame_done_out,
   output logic                      underrun_out,
   output logic                      ws2812_data_out
);

   localparam int MSB   = BITS_PER_PIXEL - 1;
   localparam int IDX_W = $clog2(BITS_PER_PIXEL);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(MSB);

   state_t             state_q;
   logic [MSB:0]       hold_q;
   logic               hold_last_q;
   logic               hold_valid_q;
   logic               hold_valid_d;
   logic               ready_q;
   logic [MSB:0]       shreg_q;
   logic               last_q;
   logic [IDX_W-1:0]   bit_idx_q;
   logic [CNT_W-1:0]   t0_q;
   logic [CNT_W-1:0]   t1_q;
   logic [CNT_W-1:0]   per_q;
   logic [LATCH_W-1:0] lat_cnt_q;
   logic               start_q;
   logic               fd_q;
   logic               ur_q;

   logic [CNT_W-1:0]   per_raw;
   logic [CNT_W-1:0]   t0_raw;
   logic [CNT_W-1:0]   t1_raw;
   logic [LATCH_W-1:0] lat_raw;
   logic               accept;
   logic               pix_end;
   logic               adv;
   logic               reload;
   logic               lat_done;
   logic               load;
   logic               bg_start;
   logic               bg_end;
   logic               bg_data;
   logic [CNT_W-1:0]   bg_th;
   logic [CNT_W-1:0]   bg_per;

   // Clamp so every bit has at least one low clock.
   assign per_raw = (period_in < CNT_W'(2)) ? CNT_W'(2) : period_in;
   assign t0_raw  = (t0h_in >= per_raw) ? per_raw - 1'b1 : t0h_in;
   assign t1_raw  = (t1h_in >= per_raw) ? per_raw - 1'b1 : t1h_in;
   assign lat_raw = (latch_in == '0) ? LATCH_W'(1) : latch_in;

   assign accept   = pix_valid_in && ready_q;
   assign pix_end  = (state_q == ST_SHIFT) && bg_end
                   && (bit_idx_q == IDX_LAST);
   assign adv      = (state_q == ST_SHIFT) && bg_end
                   && (bit_idx_q != IDX_LAST);
   assign reload   = pix_end && !last_q && hold_valid_q;
   assign lat_done = (state_q == ST_LATCH) && (lat_cnt_q == '0);
   assign load     = reload || (hold_valid_q
                   && ((state_q == ST_IDLE) || lat_done));
   assign bg_start = start_q || adv || reload;

   always_comb begin
      bg_per = per_q;
      bg_th  = shreg_q[MSB] ? t1_q : t0_q;
      unique case (1'b1)
         reload: begin
            bg_per = per_raw;
            bg_th  = hold_q[MSB] ? t1_raw : t0_raw;
         end
         adv: begin
            bg_th = shreg_q[MSB-1] ? t1_q : t0_q;
         end
         default: begin
            bg_th = shreg_q[MSB] ? t1_q : t0_q;
         end
      endcase
   end

   always_comb begin
      hold_valid_d = hold_valid_q;
      if (load) begin
         hold_valid_d = 1'b0;
      end
      if (accept) begin
         hold_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         hold_q       <= '0;
         hold_last_q  <= 1'b0;
         hold_valid_q <= 1'b0;
         ready_q      <= 1'b1;
      end else begin
         hold_valid_q <= hold_valid_d;
         ready_q      <= !hold_valid_d;
         if (accept) begin
            hold_q      <= pix_data_in;
            hold_last_q <= pix_last_in;
         end
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q   <= ST_IDLE;
         shreg_q   <= '0;
         last_q    <= 1'b0;
         bit_idx_q <= '0;
         t0_q      <= '0;
         t1_q      <= '0;
         per_q     <= '0;
         lat_cnt_q <= '0;
         start_q   <= 1'b0;
         fd_q      <= 1'b0;
         ur_q      <= 1'b0;
      end else begin
         start_q <= 1'b0;
         fd_q    <= 1'b0;
         ur_q    <= 1'b0;
         if (load) begin
            shreg_q   <= hold_q;
            last_q    <= hold_last_q;
            bit_idx_q <= '0;
            t0_q      <= t0_raw;
            t1_q      <= t1_raw;
            per_q     <= per_raw;
         end else if (adv) begin
            shreg_q   <= shreg_q << 1;
            bit_idx_q <= bit_idx_q + 1'b1;
         end
         unique case (state_q)
            ST_IDLE: begin
               if (load) begin
                  state_q <= ST_SHIFT;
                  start_q <= 1'b1;
               end
            end
            ST_SHIFT: begin
               if (pix_end && !reload) begin
                  if (last_q) begin
                     state_q   <= ST_LATCH;
                     lat_cnt_q <= lat_raw - 1'b1;
                  end else begin
                     state_q <= ST_IDLE;
                     ur_q    <= 1'b1;
                  end
               end
            end
            ST_LATCH: begin
               if (lat_done) begin
                  fd_q    <= 1'b1;
                  start_q <= load;
                  state_q <= load ? ST_SHIFT : ST_IDLE;
               end else begin
                  lat_cnt_q <= lat_cnt_q - 1'b1;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   ws2812_bit_gen #(
      .CNT_W(CNT_W)
   ) u_bit_gen (
      .clk_in   (clk_in),
      .rst_n_in (rst_n_in),
      .start_i  (bg_start),
      .th_i     (bg_th),
      .period_i (bg_per),
      .data_o   (bg_data),
      .bit_end_o(bg_end)
   );

   assign pix_ready_out   = ready_q;
   assign busy_out        = (state_q != ST_IDLE) || hold_valid_q;
   assign frame_done_out  = fd_q;
   assign underrun_out    = ur_q;
   assign ws2812_data_out = bg_data;

endmodule
